lsmitll_ndrot_bank: RTL and testbench
=====================================

# lsmitll_ndrot_bank

Cycle-based, parametrised bank of CHANNELS non-destructive-readout-with-toggle (NDROT) cells for synchronous RSFQ system models. Each channel has a set pulse, a reset pulse and a read pulse, and holds one bit of state; while set, every read toggles its output. Optional per-channel timing-window monitors turn the cell's hold constraints into cycle-count checks with sticky violation flags. Sits between pulse-level testbenches and larger RSFQ register/shift structures that need many NDROT channels behind one clock.

## Interface
- CHANNELS, 8, number of independent NDROT channels (1–64)
- Q_LAT, 1, read-to-output-toggle latency in cycles (1–4)
- WIN_RST_SET, 5, cycles after a reset pulse received in state 0 during which a set pulse is a violation (0 disables the check)
- WIN_SET_RST, 2, cycles after a set pulse received in state 1 during which a reset pulse is a violation (0 disables the check)
- WIN_RD_RD, 10, cycles after a read received in state 1 during which another read is a violation (0 disables the check)
- clk  in  1  single clock; all inputs sampled and all state updated on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- set_i  in  CHANNELS  per-channel set pulse (one-cycle strobe)
- rst_i  in  CHANNELS  per-channel reset pulse
- rd_i  in  CHANNELS  per-channel read (clock) pulse
- viol_clr_i  in  1  clears all sticky violation flags
- q_o  out  CHANNELS  toggle-encoded output; each valid read flips the bit
- state_o  out  CHANNELS  stored bit per channel
- viol_o  out  CHANNELS  sticky per-channel timing-violation flag
- viol_any_o  out  1  OR of viol_o

## Operation
- Per-channel state machine with states S0 (empty) and S1 (set). Channels are fully independent.
- S0: set_i → S1; rst_i → no change; rd_i → no output.
- S1: rst_i → S0; set_i → no change; rd_i → schedule a toggle of q_o[i] Q_LAT cycles later.
- Simultaneous set_i and rst_i in one cycle: state holds. If WIN_RST_SET>0 and the channel is in S0, or WIN_SET_RST>0 and the channel is in S1, this also counts as a violation.
- Reads see the state from before the current edge. rd_i together with set_i in S0 gives no toggle. rd_i together with rst_i in S1 gives a toggle.
- Toggle delay is a per-channel Q_LAT-deep shift register. A toggle leaving the pipeline flips q_o[i]. Back-to-back reads give one flip per cycle.
- Violation windows: each of the three checks has a per-channel down-counter of width clog2(WIN+1).
  - The counter loads WIN on its trigger event: rst_i in S0, set_i in S1, or rd_i in S1. It then decrements to 0 and saturates there.
  - A checked event arriving while the counter is non-zero sets viol_o[i]. This is a follow-up event arriving fewer than WIN cycles after the trigger.
  - A trigger event reloads its own counter.
- Violations only report. The offending event is still applied exactly as above.
- viol_o is sticky until viol_clr_i or reset. If viol_clr_i and a new violation occur in the same cycle, the new violation wins and the flag stays 1.

## Timing
- Reset values: state 0 (S0), q_o 0, toggle pipelines 0, window counters 0, viol_o 0, viol_any_o 0.
- Reset asserted mid-operation discards pending toggles. q_o returns to 0 on the first edge with rst_n=0.
- state_o updates one cycle after the set/rst strobe. q_o flips Q_LAT cycles after the read edge. viol_o sets one cycle after the violating event.
- viol_any_o is combinational from viol_o.
- Inputs are assumed synchronous to clk; there is no internal synchroniser.

## Configuration
- NDROT_TIMING_CHECK_EN defined: window counters and violation logic are built as described.
- Not defined: no counters are synthesised, viol_o and viol_any_o are tied 0, and viol_clr_i is ignored. State and q_o behaviour is bit-identical.

## Test plan
- Basic NDROT, CHANNELS=1, Q_LAT=1: set at cycle 2, reads at cycles 4, 16, 28 → q_o flips at cycles 5, 17, 29; state_o=1; viol_o=0.
- Empty read: reset, no set, reads at cycles 3 and 20 → q_o stays 0.
- Reset-then-set window, WIN_RST_SET=5: in S0, rst at cycle 10 then set at cycle 14 → state_o=1 at cycle 15 and viol_o=1. Repeat with set at cycle 15 → viol_o=0.
- Read-read window, WIN_RD_RD=10: in S1, reads at cycles 20 and 25 → two q_o flips and viol_o=1. Assert viol_clr_i at cycle 30 → viol_o=0 from cycle 31.
- Simultaneous events and latency, Q_LAT=3: set and rst together in S0 → state stays 0 and viol_o=1. In S1, rd with rst at cycle 40 → q_o flips at cycle 43 and state_o=0 at cycle 41.
- Reset mid-pipeline, Q_LAT=4, channels 0 and 7 set, reads at cycle 50, rst_n low at cycle 52 → no flip at cycle 54; all outputs 0. Rebuild without NDROT_TIMING_CHECK_EN and repeat the violation scenarios → viol_o always 0.

Source files
------------

// File: rtl/lsmitll_ndrot_bank.sv
// Cycle-based bank of NDROT cells: per-channel set/reset/read, toggle-encoded output.
// Optional hold-window monitors are built when NDROT_TIMING_CHECK_EN is defined.

module lsmitll_ndrot_win #(
  parameter int CHANNELS = 8,
  parameter int WIN      = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] trig,
  input  logic [CHANNELS-1:0] chk,
  output logic [CHANNELS-1:0] hit
);
  if (WIN > 0) begin : g_win
    localparam int CW = $clog2(WIN + 1);
    logic [CW-1:0] cnt_q [CHANNELS];

    // A value of 1 expires on this same edge, so only >1 means "fewer than WIN cycles since the trigger".
    always_comb begin
      for (int i = 0; i < CHANNELS; i++) hit[i] = chk[i] && (cnt_q[i] > CW'(1));
    end

    // NOTE: counter arrays are reset explicitly; a stale window must not survive rst_n.
    always_ff @(posedge clk) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!rst_n)           cnt_q[i] <= '0;
        else if (trig[i])     cnt_q[i] <= CW'(WIN);
        else if (cnt_q[i] != '0) cnt_q[i] <= cnt_q[i] - CW'(1);
      end
    end
  end else begin : g_nowin
    logic unused_win;
    assign unused_win = ^{clk, rst_n, trig, chk};
    assign hit = '0;
  end
endmodule

module lsmitll_ndrot_bank #(
  parameter int CHANNELS    = 8,
  parameter int Q_LAT       = 1,
  parameter int WIN_RST_SET = 5,
  parameter int WIN_SET_RST = 2,
  parameter int WIN_RD_RD   = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] set_i,
  input  logic [CHANNELS-1:0] rst_i,
  input  logic [CHANNELS-1:0] rd_i,
  input  logic                viol_clr_i,
  output logic [CHANNELS-1:0] q_o,
  output logic [CHANNELS-1:0] state_o,
  output logic [CHANNELS-1:0] viol_o,
  output logic                viol_any_o
);
  typedef enum logic {S0 = 1'b0, S1 = 1'b1} ndrot_state_e;

  ndrot_state_e        state_q [CHANNELS];
  ndrot_state_e        state_d [CHANNELS];
  logic [Q_LAT-1:0]    pipe_q  [CHANNELS];
  logic [CHANNELS-1:0] q_q;
  logic [CHANNELS-1:0] rd_hit;
  logic [CHANNELS-1:0] in_s1;

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (!rst_n) state_q[i] <= S0;
      else        state_q[i] <= state_d[i];
    end
  end

  // NOTE: every comb output gets a default first so no latch is inferred.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      if (set_i[i] && !rst_i[i])      state_d[i] = S1;
      else if (rst_i[i] && !set_i[i]) state_d[i] = S0;
    end
  end

  // Reads act on the pre-edge state, so rd with rst in S1 still toggles.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      in_s1[i]  = (state_q[i] == S1);
      rd_hit[i] = rd_i[i] && in_s1[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (!rst_n) begin
        pipe_q[i] <= '0;
        q_q[i]    <= 1'b0;
      end else begin
        pipe_q[i] <= (pipe_q[i] << 1) | Q_LAT'(rd_hit[i]);
        q_q[i]    <= q_q[i] ^ pipe_q[i][Q_LAT-1];
      end
    end
  end

  assign q_o     = q_q;
  assign state_o = in_s1;

`ifdef NDROT_TIMING_CHECK_EN
  logic [CHANNELS-1:0] hit_rs, hit_sr, hit_rr, both, viol_new, viol_q;

  lsmitll_ndrot_win #(.CHANNELS(CHANNELS), .WIN(WIN_RST_SET)) u_win_rs (
    .clk(clk), .rst_n(rst_n), .trig(rst_i & ~in_s1), .chk(set_i), .hit(hit_rs));
  lsmitll_ndrot_win #(.CHANNELS(CHANNELS), .WIN(WIN_SET_RST)) u_win_sr (
    .clk(clk), .rst_n(rst_n), .trig(set_i & in_s1), .chk(rst_i), .hit(hit_sr));
  lsmitll_ndrot_win #(.CHANNELS(CHANNELS), .WIN(WIN_RD_RD)) u_win_rr (
    .clk(clk), .rst_n(rst_n), .trig(rd_hit), .chk(rd_i), .hit(hit_rr));

  assign both     = set_i & rst_i;
  assign viol_new = hit_rs | hit_sr | hit_rr
                  | (both & ~in_s1 & {CHANNELS{WIN_RST_SET > 0}})
                  | (both &  in_s1 & {CHANNELS{WIN_SET_RST > 0}});

  // A new violation overrides a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) viol_q <= '0;
    else        viol_q <= (viol_q & ~{CHANNELS{viol_clr_i}}) | viol_new;
  end

  assign viol_o = viol_q;
`else
  logic unused_clr;
  assign unused_clr = viol_clr_i;
  assign viol_o     = '0;
`endif

  assign viol_any_o = |viol_o;
endmodule

// File: tb/tb_lsmitll_ndrot_bank.sv
// Self-checking bench for lsmitll_ndrot_bank: directed scenarios then random pulses,
// compared against an event-time reference model.

module tb_lsmitll_ndrot_bank;
  localparam int CH   = 8;
  localparam int QL   = 3;
  localparam int W_RS = 5;
  localparam int W_SR = 2;
  localparam int W_RR = 10;
`ifdef NDROT_TIMING_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] set_i = '0, rst_i = '0, rd_i = '0;
  logic          viol_clr_i = 1'b0;
  logic [CH-1:0] q_o, state_o, viol_o;
  logic          viol_any_o;

  lsmitll_ndrot_bank #(.CHANNELS(CH), .Q_LAT(QL), .WIN_RST_SET(W_RS),
                       .WIN_SET_RST(W_SR), .WIN_RD_RD(W_RR)) dut (
    .clk(clk), .rst_n(rst_n), .set_i(set_i), .rst_i(rst_i), .rd_i(rd_i),
    .viol_clr_i(viol_clr_i), .q_o(q_o), .state_o(state_o), .viol_o(viol_o),
    .viol_any_o(viol_any_o));

  always #5 clk = ~clk;

  // Reference model: bits plus the cycle of the last trigger for each window.
  logic [CH-1:0] m_state, m_q, m_viol;
  int            t_rs [CH], t_sr [CH], t_rr [CH];
  logic [CH-1:0] flips [int];
  int            cyc = 0;
  int            errors = 0, checks = 0;

  task automatic model_reset();
    m_state = '0; m_q = '0; m_viol = '0;
    flips.delete();
    for (int i = 0; i < CH; i++) begin
      t_rs[i] = -1000; t_sr[i] = -1000; t_rr[i] = -1000;
    end
  endtask

  task automatic model_edge(input logic [CH-1:0] s, r, d, input logic clr);
    logic [CH-1:0] nv;
    nv = '0;
    for (int i = 0; i < CH; i++) begin
      if (s[i] && r[i] && ((W_RS > 0 && !m_state[i]) || (W_SR > 0 && m_state[i]))) nv[i] = 1'b1;
      if (s[i] && (cyc - t_rs[i] < W_RS)) nv[i] = 1'b1;
      if (r[i] && (cyc - t_sr[i] < W_SR)) nv[i] = 1'b1;
      if (d[i] && (cyc - t_rr[i] < W_RR)) nv[i] = 1'b1;
      if (r[i] && !m_state[i]) t_rs[i] = cyc;
      if (s[i] &&  m_state[i]) t_sr[i] = cyc;
      if (d[i] &&  m_state[i]) begin
        t_rr[i] = cyc;
        if (!flips.exists(cyc + QL)) flips[cyc + QL] = '0;
        flips[cyc + QL][i] = 1'b1;
      end
      if (s[i] && !r[i])      m_state[i] = 1'b1;
      else if (r[i] && !s[i]) m_state[i] = 1'b0;
    end
    if (flips.exists(cyc)) begin
      m_q = m_q ^ flips[cyc];
      flips.delete(cyc);
    end
    m_viol = CHK ? ((m_viol & ~{CH{clr}}) | nv) : '0;
  endtask

  task automatic step(input logic rn, input logic [CH-1:0] s, r, d,
                      input logic clr, input string tag);
    rst_n = rn; set_i = s; rst_i = r; rd_i = d; viol_clr_i = clr;
    @(posedge clk);
    cyc++;
    if (!rn) model_reset();
    else     model_edge(s, r, d, clr);
    #1;
    checks++;
    assert (q_o === m_q) else begin
      errors++; $error("FAIL %s q_o got=%h exp=%h cyc=%0d", tag, q_o, m_q, cyc);
    end
    checks++;
    assert (state_o === m_state) else begin
      errors++; $error("FAIL %s state_o got=%h exp=%h cyc=%0d", tag, state_o, m_state, cyc);
    end
    checks++;
    assert (viol_o === m_viol) else begin
      errors++; $error("FAIL %s viol_o got=%h exp=%h cyc=%0d", tag, viol_o, m_viol, cyc);
    end
    checks++;
    assert (viol_any_o === (|m_viol)) else begin
      errors++; $error("FAIL %s viol_any_o got=%b exp=%b cyc=%0d", tag, viol_any_o, |m_viol, cyc);
    end
  endtask

  task automatic idle(input int n, input string tag);
    for (int k = 0; k < n; k++) step(1'b1, '0, '0, '0, 1'b0, tag);
  endtask

  initial begin
    model_reset();
    step(1'b0, '0, '0, '0, 1'b0, "reset");
    step(1'b0, 8'hFF, '0, 8'hFF, 1'b1, "reset_hold");

    // Basic NDROT on ch0: set, then reads spaced beyond the read window.
    step(1'b1, 8'h01, '0, '0, 1'b0, "set0");
    idle(1, "basic");
    step(1'b1, '0, '0, 8'h01, 1'b0, "read0_a");
    idle(11, "basic_lat");
    step(1'b1, '0, '0, 8'h01, 1'b0, "read0_b");
    idle(11, "basic_lat");

    // Empty read on ch1.
    step(1'b1, '0, '0, 8'h02, 1'b0, "empty_rd");
    idle(4, "empty_wait");

    // Reset-then-set window on ch2: 4 cycles later violates, 5 cycles does not.
    step(1'b1, '0, 8'h04, '0, 1'b0, "rs_rst");
    idle(3, "rs_gap");
    step(1'b1, 8'h04, '0, '0, 1'b0, "rs_set_close");
    idle(1, "rs_hold");
    step(1'b1, '0, '0, '0, 1'b1, "rs_clr");
    step(1'b1, '0, 8'h04, '0, 1'b0, "rs_back_s0");
    idle(2, "rs_gap2");
    step(1'b1, '0, 8'h04, '0, 1'b0, "rs_rst2");
    idle(4, "rs_gap3");
    step(1'b1, 8'h04, '0, '0, 1'b0, "rs_set_far");
    idle(2, "rs_hold2");

    // Read-read window on ch0 (in S1), then clear.
    step(1'b1, '0, '0, 8'h01, 1'b0, "rr_rd1");
    idle(4, "rr_gap");
    step(1'b1, '0, '0, 8'h01, 1'b0, "rr_rd2");
    idle(4, "rr_lat");
    step(1'b1, '0, '0, '0, 1'b1, "rr_clr");
    idle(1, "rr_after_clr");

    // Simultaneous set+rst in S0 on ch3; rd with rst in S1 on ch4.
    step(1'b1, 8'h08, 8'h08, '0, 1'b0, "sim_s0");
    step(1'b1, 8'h10, '0, '0, 1'b0, "set4");
    idle(3, "gap4");
    step(1'b1, '0, 8'h10, 8'h10, 1'b0, "rd_rst4");
    idle(4, "lat4");

    // Clear coinciding with a new violation: the new one wins.
    step(1'b1, 8'h08, 8'h08, '0, 1'b1, "clr_vs_new");
    step(1'b1, '0, '0, '0, 1'b1, "clr_all");

    // Reset mid-pipeline discards pending toggles.
    step(1'b1, 8'h80, '0, '0, 1'b0, "set7");
    idle(2, "gap7");
    step(1'b1, '0, '0, 8'h81, 1'b0, "rd_0_7");
    idle(1, "pipe");
    step(1'b0, '0, '0, '0, 1'b0, "rst_mid");
    idle(5, "after_rst");

    // Randomised sparse pulses across all channels.
    for (int n = 0; n < 600; n++) begin
      logic [CH-1:0] s, r, d;
      s = CH'($urandom & $urandom & $urandom);
      r = CH'($urandom & $urandom & $urandom);
      d = CH'($urandom & $urandom);
      step(($urandom_range(0, 149) != 0), s, r, d, ($urandom_range(0, 19) == 0), "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
